// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key conditioning front end.
//   - Key index constants naming the bit position of each button.
//   - key_state_t: per-key debounce / auto-repeat state encoding.
//   - clog2(): constant ceiling-log2, never narrower than one bit, used to
//     size the shared timebase and the per-key tick counters.
// ---------------------------------------------------------------------------
package key_pkg;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_EXIT  = 4;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD_DELAY   = 3'd2,
        HELD_REPEAT  = 3'd3,
        RELEASE_WAIT = 3'd4
    } key_state_t;

    // Ceiling log2, clamped to 1 so a counter sized from it always exists
    // even when every tick parameter is 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/key_channel.sv
// ---------------------------------------------------------------------------
// key_channel
// One key: 2-flop synchroniser, polarity normalisation, and a debounce /
// auto-repeat state machine counting shared timebase ticks.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   tick               : one-cycle timebase strobe from the top level
//   key_raw            : raw asynchronous button pin
//   repeat_en          : auto-repeat enable, sampled every cycle
//   key_pulse          : registered one-cycle press / repeat pulse
//   key_level          : registered debounced pressed level
// ---------------------------------------------------------------------------
module key_channel
    import key_pkg::*;
#(
    parameter int ACTIVE_LOW          = 1,
    parameter int DEBOUNCE_TICKS      = 20,
    parameter int REPEAT_DELAY_TICKS  = 500,
    parameter int REPEAT_PERIOD_TICKS = 100
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic tick,
    input  logic key_raw,
    input  logic repeat_en,
    output logic key_pulse,
    output logic key_level
);

    localparam int MAX_A     = (DEBOUNCE_TICKS > REPEAT_DELAY_TICKS) ? DEBOUNCE_TICKS : REPEAT_DELAY_TICKS;
    localparam int MAX_TICKS = (MAX_A > REPEAT_PERIOD_TICKS) ? MAX_A : REPEAT_PERIOD_TICKS;
    localparam int CNT_W     = clog2(MAX_TICKS);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD_TICKS - 1);

    // Pin level that means "not pressed"; the synchroniser resets to it so
    // a key held through reset still has to be debounced from scratch.
    localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);

    logic             sync_q1;
    logic             sync_q2;
    logic             pressed;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser bringing the asynchronous pin into sys_clk.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1 <= RELEASED_RAW;
            sync_q2 <= RELEASED_RAW;
        end else begin
            sync_q1 <= key_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

    // Debounce and auto-repeat state machine. In every state a change of
    // the pressed level is tested before the tick, so it wins over a tick
    // on the same edge. The counter holds the number of ticks already seen
    // in the current state; HELD_DELAY saturates it instead of wrapping so
    // a long hold without repeat never produces a stray pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            key_pulse <= 1'b0;
            key_level <= 1'b0;
        end else begin
            key_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    key_level <= 1'b0;
                    if (pressed) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (cnt == DEB_LAST) begin
                            state     <= HELD_DELAY;
                            cnt       <= '0;
                            key_level <= 1'b1;
                            key_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HELD_DELAY: begin
                    if (!pressed) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == DLY_LAST) begin
                            if (repeat_en) begin
                                state     <= HELD_REPEAT;
                                cnt       <= '0;
                                key_pulse <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HELD_REPEAT: begin
                    if (!pressed) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (!repeat_en) begin
                        state <= HELD_DELAY;
                        cnt   <= DLY_LAST;
                    end else if (tick) begin
                        if (cnt == PER_LAST) begin
                            cnt       <= '0;
                            key_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed) begin
                        state <= HELD_DELAY;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == DEB_LAST) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            key_level <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    key_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
// Turns raw bouncing push-buttons into clean one-cycle press / repeat
// pulses plus debounced held levels, one independent channel per key.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   key_raw[N_KEYS]    : raw asynchronous button pins
//   repeat_en[N_KEYS]  : per-key auto-repeat enable
//   key_pulse[N_KEYS]  : one-cycle pulse per accepted press or repeat
//   key_level[N_KEYS]  : debounced pressed level
//   key_any            : OR of key_pulse in the same cycle
// ---------------------------------------------------------------------------
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS              = KEY_EXIT + 1,
    parameter int ACTIVE_LOW          = 1,
    parameter int TICK_CYCLES         = 50000,
    parameter int DEBOUNCE_TICKS      = 20,
    parameter int REPEAT_DELAY_TICKS  = 500,
    parameter int REPEAT_PERIOD_TICKS = 100
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] key_pulse,
    output logic [N_KEYS-1:0] key_level,
    output logic              key_any
);

    localparam int                TICK_W    = clog2(TICK_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    // Free-running timebase shared by all keys. It is never re-aligned to
    // key activity, which is why press latency varies by up to one tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // One fully independent channel per key; simultaneous pulses pass
    // through unarbitrated.
    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_channel #(
            .ACTIVE_LOW          (ACTIVE_LOW),
            .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
            .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
            .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS)
        ) u_channel (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .tick      (tick),
            .key_raw   (key_raw[k]),
            .repeat_en (repeat_en[k]),
            .key_pulse (key_pulse[k]),
            .key_level (key_level[k])
        );
    end

    assign key_any = |key_pulse;

endmodule

// File: tb/tb_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_conditioner
// Self-checking bench for key_conditioner with a short timebase
// (4 cycles/tick, 3 debounce ticks, repeat delay 5, repeat period 2).
// Expected pulses are queued with an allowed cycle window when stimulus is
// applied; a negedge monitor pops and checks each observed pulse.
// ---------------------------------------------------------------------------
module tb_key_conditioner;
    import key_pkg::*;

    localparam int NK = 5;

    typedef struct packed {
        logic [NK-1:0] mask;
        int            lo;
        int            hi;
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic [NK-1:0] key_raw = '1;
    logic [NK-1:0] repeat_en = '0;
    logic [NK-1:0] key_pulse;
    logic [NK-1:0] key_level;
    logic          key_any;

    exp_t sb[$];
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_pulse_cycle = 0;

    key_conditioner #(
        .N_KEYS              (NK),
        .ACTIVE_LOW          (1),
        .TICK_CYCLES         (4),
        .DEBOUNCE_TICKS      (3),
        .REPEAT_DELAY_TICKS  (5),
        .REPEAT_PERIOD_TICKS (2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_raw   (key_raw),
        .repeat_en (repeat_en),
        .key_pulse (key_pulse),
        .key_level (key_level),
        .key_any   (key_any)
    );

    // Clock and cycle counter.
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cycle <= cycle + 1;

    // Scoreboard consumer: every pulse seen must match the oldest queued
    // expectation in mask and in timing window.
    always @(negedge sys_clk) begin : mon
        exp_t e;
        if (sys_rst_n && key_pulse != '0) begin
            last_pulse_cycle = cycle;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse: got key_pulse=%b at cycle %0d, expected none", key_pulse, cycle);
            end else begin
                e = sb.pop_front();
                if (key_pulse !== e.mask) begin
                    errors++;
                    $display("[TB] FAIL pulse_mask: got %b, expected %b (cycle %0d)", key_pulse, e.mask, cycle);
                end
                checks++;
                if (cycle < e.lo || cycle > e.hi) begin
                    errors++;
                    $display("[TB] FAIL pulse_time: got cycle %0d, expected %0d..%0d", cycle, e.lo, e.hi);
                end
            end
            checks++;
            if (key_any !== 1'b1) begin
                errors++;
                $display("[TB] FAIL key_any: got %b, expected 1 (cycle %0d)", key_any, cycle);
            end
            checks++;
            if ((key_level & key_pulse) !== key_pulse) begin
                errors++;
                $display("[TB] FAIL level_with_pulse: got key_level=%b, expected set under key_pulse=%b", key_level, key_pulse);
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_sb_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) step();
    endtask

    task automatic wait_levels_low(input logic [NK-1:0] mask, input int max_cycles);
        for (int i = 0; i < max_cycles && (key_level & mask) != '0; i++) step();
    endtask

    // Reset clears all outputs asynchronously and the bench idles cleanly.
    task automatic test_reset();
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (key_pulse !== '0 || key_level !== '0 || key_any !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got pulse=%b level=%b any=%b, expected all 0", key_pulse, key_level, key_any);
        end
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (20) step();
        checks++;
        if (key_level !== '0 || key_any !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got level=%b any=%b, expected 0", key_level, key_any);
        end
    endtask

    // Single clean press on key 1 without repeat.
    task automatic test_clean_press();
        int c;
        step();
        c = cycle;
        key_raw[KEY_DOWN] = 1'b0;
        sb.push_back('{mask: 5'b00010, lo: c + 12, hi: c + 15});
        repeat (11) step();
        checks++;
        if (key_level[KEY_DOWN] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL press_level_early: got %b, expected 0", key_level[KEY_DOWN]);
        end
        wait_sb_drain(10);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL press_missing: got %0d pending pulses, expected 0", sb.size());
        end
        checks++;
        if (key_level[KEY_DOWN] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL press_level: got %b, expected 1", key_level[KEY_DOWN]);
        end
        while (cycle < c + 30) step();
        key_raw[KEY_DOWN] = 1'b1;
        wait_levels_low(5'b00010, 40);
        checks++;
        if (key_level[KEY_DOWN] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL press_release_level: got %b, expected 0", key_level[KEY_DOWN]);
        end
    endtask

    // Key 0 chatters every 3 cycles: never long enough to be accepted.
    task automatic test_bounce();
        bit seen_level;
        seen_level = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) key_raw[KEY_UP] = ~key_raw[KEY_UP];
            step();
            if (key_level[KEY_UP] !== 1'b0) seen_level = 1'b1;
        end
        key_raw[KEY_UP] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (key_level[KEY_UP] !== 1'b0) seen_level = 1'b1;
        end
        checks++;
        if (seen_level !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bounce_level: got level high at some point, expected always 0");
        end
    endtask

    // Release of key 2 with a short glitch restarts the release debounce.
    task automatic test_release_debounce();
        int c, r;
        bit dropped_early;
        dropped_early = 1'b0;
        step();
        c = cycle;
        key_raw[KEY_LEFT] = 1'b0;
        sb.push_back('{mask: 5'b00100, lo: c + 12, hi: c + 15});
        wait_sb_drain(20);
        checks++;
        if (sb.size() != 0 || key_level[KEY_LEFT] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_setup: got pending=%0d level=%b, expected 0 and 1", sb.size(), key_level[KEY_LEFT]);
        end
        step();
        r = cycle;
        key_raw[KEY_LEFT] = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            step();
            if (cycle == r + 5) key_raw[KEY_LEFT] = 1'b0;
            if (cycle == r + 7) key_raw[KEY_LEFT] = 1'b1;
            if (cycle <= r + 18 && key_level[KEY_LEFT] !== 1'b1) dropped_early = 1'b1;
        end
        checks++;
        if (dropped_early !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_early: got level drop before cycle %0d, expected none", r + 19);
        end
        checks++;
        if (key_level[KEY_LEFT] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_level: got %b at cycle %0d, expected 0", key_level[KEY_LEFT], cycle);
        end
    endtask

    // Keys 0 and 3 pressed together pulse in the same cycle.
    task automatic test_simultaneous();
        int c;
        step();
        c = cycle;
        key_raw[KEY_UP]    = 1'b0;
        key_raw[KEY_RIGHT] = 1'b0;
        sb.push_back('{mask: 5'b01001, lo: c + 12, hi: c + 15});
        wait_sb_drain(20);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL simul_missing: got %0d pending pulses, expected 0", sb.size());
        end
        checks++;
        if (key_level !== 5'b01001) begin
            errors++;
            $display("[TB] FAIL simul_level: got %b, expected 01001", key_level);
        end
        key_raw = '1;
        wait_levels_low('1, 30);
        checks++;
        if (key_level !== '0) begin
            errors++;
            $display("[TB] FAIL simul_release: got %b, expected 00000", key_level);
        end
    endtask

    // Key 3 held with repeat: first pulse T, then T+20 and every 8 cycles.
    task automatic test_auto_repeat();
        int c, t;
        repeat_en[KEY_RIGHT] = 1'b1;
        step();
        c = cycle;
        key_raw[KEY_RIGHT] = 1'b0;
        sb.push_back('{mask: 5'b01000, lo: c + 12, hi: c + 15});
        wait_sb_drain(20);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL repeat_first_missing: got %0d pending, expected 0", sb.size());
        end
        t = last_pulse_cycle;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{mask: 5'b01000, lo: t + 20 + 8 * k, hi: t + 20 + 8 * k});
        end
        while (cycle < c + 60) step();
        key_raw[KEY_RIGHT] = 1'b1;
        wait_sb_drain(10);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL repeat_missing: got %0d pending repeats, expected 0", sb.size());
        end
        wait_levels_low(5'b01000, 30);
        checks++;
        if (key_level[KEY_RIGHT] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL repeat_release: got %b, expected 0", key_level[KEY_RIGHT]);
        end
        repeat_en[KEY_RIGHT] = 1'b0;
    endtask

    // Reset asserted between edges while key 3 is repeating.
    task automatic test_reset_mid_hold();
        int c, t, c2;
        repeat_en[KEY_RIGHT] = 1'b1;
        step();
        c = cycle;
        key_raw[KEY_RIGHT] = 1'b0;
        sb.push_back('{mask: 5'b01000, lo: c + 12, hi: c + 15});
        wait_sb_drain(20);
        t = last_pulse_cycle;
        sb.push_back('{mask: 5'b01000, lo: t + 20, hi: t + 20});
        for (int i = 0; i < 40 && cycle < t + 20; i++) step();
        @(negedge sys_clk);
        #1;
        checks++;
        if (key_pulse !== 5'b01000 || key_level[KEY_RIGHT] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_before_reset: got pulse=%b level=%b, expected 01000 and 1", key_pulse, key_level[KEY_RIGHT]);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (key_pulse !== '0 || key_level !== '0 || key_any !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: got pulse=%b level=%b any=%b, expected all 0", key_pulse, key_level, key_any);
        end
        repeat_en[KEY_RIGHT] = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        c2 = cycle;
        sb.push_back('{mask: 5'b01000, lo: c2 + 12, hi: c2 + 15});
        wait_sb_drain(20);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_repress_missing: got %0d pending, expected 0", sb.size());
        end
        key_raw[KEY_RIGHT] = 1'b1;
        wait_levels_low(5'b01000, 30);
        checks++;
        if (key_level[KEY_RIGHT] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b, expected 0", key_level[KEY_RIGHT]);
        end
    endtask

    initial begin
        $display("[TB] key_conditioner bench start");
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_debounce();
        test_simultaneous();
        test_auto_repeat();
        test_reset_mid_hold();
        repeat (10) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got %0d leftover expectations, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
